// File: rtl/delay_output_merge.sv
// delay_output_merge: two-channel ready/valid merger for the delay unit outputs.
// Each input channel is buffered in a small FIFO. A round-robin arbiter then
// moves one beat per cycle into a registered output stage. O_tag carries the
// index of the channel that supplied each output beat.
// Optional build macro: DELAY_OUTPUT_MERGE_ASSERT_EN compiles in SVA checks.
// These checks cover overflow, output stability, arbitration fairness and the
// occupancy bound. Defining the macro does not change the RTL behaviour.
module delay_output_merge #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [WIDTH-1:0] I_0_data,
    input  logic             I_0_valid,
    output logic             I_0_ready,
    input  logic [WIDTH-1:0] I_1_data,
    input  logic             I_1_valid,
    output logic             I_1_ready,
    output logic [WIDTH-1:0] O_data,
    output logic             O_tag,
    output logic             O_valid,
    input  logic             O_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Per-channel views of the two input ports so that a single generate loop
    // can build both FIFOs.
    logic [WIDTH-1:0] in_data   [2];
    logic [WIDTH-1:0] head_data [2];
    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [1:0]       not_empty;
    logic [1:0]       pop;

    assign in_data[0]  = I_0_data;
    assign in_data[1]  = I_1_data;
    assign in_valid[0] = I_0_valid;
    assign in_valid[1] = I_1_valid;
    assign I_0_ready   = in_ready[0];
    assign I_1_ready   = in_ready[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [WIDTH-1:0] mem_q [DEPTH];
            logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
            logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
            logic [CW-1:0]    count_q, count_d;
            logic             push;

            // Readiness looks only at local occupancy. A pop in the same cycle
            // does not make room early.
            assign in_ready[gi]  = (count_q < FULL_COUNT) && !ASYNCRESET;
            assign push          = in_valid[gi] && in_ready[gi];
            assign not_empty[gi] = (count_q != '0);
            assign head_data[gi] = mem_q[rd_ptr_q];

            // Next pointers and occupancy from this cycle's push/pop pair
            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
                if (pop[gi]) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
                case ({push, pop[gi]})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
            end

            // FIFO control state. Reset empties the FIFO immediately.
            always_ff @(posedge CLK or posedge ASYNCRESET) begin
                if (ASYNCRESET) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            // Payload storage. Stale entries are unreachable once count is cleared.
            always_ff @(posedge CLK) begin
                if (push) begin
                    mem_q[wr_ptr_q] <= in_data[gi];
                end
            end

`ifdef DELAY_OUTPUT_MERGE_ASSERT_EN
            // A push must never land in a full FIFO.
            a_no_overflow: assert property (@(posedge CLK) disable iff (ASYNCRESET)
                push |-> (count_q < FULL_COUNT));
            // Occupancy is bounded by the FIFO capacity.
            a_count_bound: assert property (@(posedge CLK) disable iff (ASYNCRESET)
                count_q <= FULL_COUNT);
`endif
        end
    endgenerate

    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] o_data_q, o_data_d;
    logic             o_tag_q, o_tag_d;
    logic             last_grant_q, last_grant_d;
    logic             grant;
    logic             load;

    // Round-robin arbitration and next state of the output register
    always_comb begin
        grant = 1'b0;
        if (not_empty[0] && not_empty[1]) begin
            grant = !last_grant_q;
        end else if (not_empty[1]) begin
            grant = 1'b1;
        end
        load         = (!o_valid_q || O_ready) && (not_empty != 2'b00);
        pop[0]       = load && !grant;
        pop[1]       = load && grant;
        o_valid_d    = o_valid_q;
        o_data_d     = o_data_q;
        o_tag_d      = o_tag_q;
        last_grant_d = last_grant_q;
        if (load) begin
            o_valid_d    = 1'b1;
            o_data_d     = head_data[grant];
            o_tag_d      = grant;
            last_grant_d = grant;
        end else if (o_valid_q && O_ready) begin
            o_valid_d = 1'b0;
        end
    end

    // Output stage registers. last_grant resets to 1 so channel 0 wins the first tie.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            o_valid_q    <= 1'b0;
            o_data_q     <= '0;
            o_tag_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            o_valid_q    <= o_valid_d;
            o_data_q     <= o_data_d;
            o_tag_q      <= o_tag_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign O_valid = o_valid_q;
    assign O_data  = o_data_q;
    assign O_tag   = o_tag_q;

`ifdef DELAY_OUTPUT_MERGE_ASSERT_EN
    // A stalled beat must stay valid and must not change.
    a_stall_stable: assert property (@(posedge CLK) disable iff (ASYNCRESET)
        (O_valid && !O_ready) |=> (O_valid && $stable(O_data) && $stable(O_tag)));
    // When both FIFOs hold data, the grant alternates. Any non-empty channel is
    // therefore served within two output transfers.
    a_fair_alternate: assert property (@(posedge CLK) disable iff (ASYNCRESET)
        (load && (not_empty == 2'b11)) |-> (grant != last_grant_q));
    // When only one FIFO holds data, that FIFO is always granted.
    a_single_grant: assert property (@(posedge CLK) disable iff (ASYNCRESET)
        (load && (not_empty != 2'b11)) |-> (grant == not_empty[1]));
`endif

endmodule

// File: tb/tb_delay_output_merge.sv
// Directed testbench for delay_output_merge (WIDTH=5, DEPTH=2).
// Inputs are driven and outputs are sampled around the falling clock edge.
module tb_delay_output_merge;

    localparam int WIDTH = 5;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             ASYNCRESET = 1'b0;
    logic [WIDTH-1:0] I_0_data = '0;
    logic             I_0_valid = 1'b0;
    logic             I_0_ready;
    logic [WIDTH-1:0] I_1_data = '0;
    logic             I_1_valid = 1'b0;
    logic             I_1_ready;
    logic [WIDTH-1:0] O_data;
    logic             O_tag;
    logic             O_valid;
    logic             O_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    delay_output_merge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK        (clk),
        .ASYNCRESET (ASYNCRESET),
        .I_0_data   (I_0_data),
        .I_0_valid  (I_0_valid),
        .I_0_ready  (I_0_ready),
        .I_1_data   (I_1_data),
        .I_1_valid  (I_1_valid),
        .I_1_ready  (I_1_ready),
        .O_data     (O_data),
        .O_tag      (O_tag),
        .O_valid    (O_valid),
        .O_ready    (O_ready)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Clear all inputs, pulse reset and release it on a falling edge.
    task automatic do_reset();
        I_0_valid  = 1'b0;
        I_1_valid  = 1'b0;
        I_0_data   = '0;
        I_1_data   = '0;
        O_ready    = 1'b0;
        ASYNCRESET = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ASYNCRESET = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        ASYNCRESET = 1'b1;
        I_0_valid  = 1'b1;
        I_1_valid  = 1'b1;
        @(negedge clk);
        n_checks++; if (O_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", O_valid); end
        n_checks++; if (O_data !== 5'h00) begin n_fail++; $display("FAIL reset_o_data: got %h want 00", O_data); end
        n_checks++; if (O_tag !== 1'b0) begin n_fail++; $display("FAIL reset_o_tag: got %b want 0", O_tag); end
        n_checks++; if (I_0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_i0_ready: got %b want 0", I_0_ready); end
        n_checks++; if (I_1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_i1_ready: got %b want 0", I_1_ready); end
        I_0_valid  = 1'b0;
        I_1_valid  = 1'b0;
        ASYNCRESET = 1'b0;
        #1;
        n_checks++; if (I_0_ready !== 1'b1) begin n_fail++; $display("FAIL release_i0_ready: got %b want 1", I_0_ready); end
        n_checks++; if (I_1_ready !== 1'b1) begin n_fail++; $display("FAIL release_i1_ready: got %b want 1", I_1_ready); end
        $display("reset: done");
    endtask

    task automatic test_single_beat();
        do_reset();
        O_ready   = 1'b1;
        I_0_valid = 1'b1;
        I_0_data  = 5'h0A;
        @(negedge clk);
        I_0_valid = 1'b0;
        n_checks++; if (O_valid !== 1'b0) begin n_fail++; $display("FAIL single_not_early: got %b want 0", O_valid); end
        @(negedge clk);
        n_checks++; if (O_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", O_valid); end
        n_checks++; if (O_data !== 5'h0A) begin n_fail++; $display("FAIL single_data: got %h want 0a", O_data); end
        n_checks++; if (O_tag !== 1'b0) begin n_fail++; $display("FAIL single_tag: got %b want 0", O_tag); end
        $display("single: beat tag=%0d data=%h", O_tag, O_data);
        @(negedge clk);
        n_checks++; if (O_valid !== 1'b0) begin n_fail++; $display("FAIL single_clear: got %b want 0", O_valid); end
        n_checks++; if (O_data !== 5'h0A) begin n_fail++; $display("FAIL single_hold_data: got %h want 0a", O_data); end
    endtask

    task automatic test_contention();
        logic [WIDTH-1:0] got_data [8];
        logic             got_tag  [8];
        logic [WIDTH-1:0] exp_data;
        logic             exp_tag;
        logic             acc0, acc1;
        int idx0, idx1, n;
        do_reset();
        O_ready = 1'b1;
        idx0 = 0; idx1 = 0; n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            I_0_valid = (idx0 < 4);
            I_0_data  = 5'(8'h01 + idx0);
            I_1_valid = (idx1 < 4);
            I_1_data  = 5'(8'h11 + idx1);
            acc0 = I_0_valid && I_0_ready;
            acc1 = I_1_valid && I_1_ready;
            if (O_valid === 1'b1) begin
                got_data[n] = O_data;
                got_tag[n]  = O_tag;
                $display("contention: beat %0d tag=%0d data=%h", n, O_tag, O_data);
                n++;
            end
            @(negedge clk);
            if (acc0) idx0++;
            if (acc1) idx1++;
        end
        I_0_valid = 1'b0;
        I_1_valid = 1'b0;
        n_checks++; if (n != 8) begin n_fail++; $display("FAIL contention_count: got %0d beats want 8", n); end
        for (int i = 0; i < n; i++) begin
            exp_tag  = (i % 2) == 1;
            exp_data = exp_tag ? 5'(8'h11 + i / 2) : 5'(8'h01 + i / 2);
            n_checks++; if (got_tag[i] !== exp_tag) begin n_fail++; $display("FAIL contention_tag[%0d]: got %b want %b", i, got_tag[i], exp_tag); end
            n_checks++; if (got_data[i] !== exp_data) begin n_fail++; $display("FAIL contention_data[%0d]: got %h want %h", i, got_data[i], exp_data); end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] got_data [4];
        int               got_cyc  [4];
        logic             acc;
        int idx, n;
        do_reset();
        O_ready = 1'b1;
        idx = 0; n = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            I_1_valid = (idx < 4);
            I_1_data  = 5'(8'h15 + idx);
            acc = I_1_valid && I_1_ready;
            if (O_valid === 1'b1) begin
                got_data[n] = O_data;
                got_cyc[n]  = c;
                $display("back_to_back: beat %0d tag=%0d data=%h cycle=%0d", n, O_tag, O_data, c);
                n_checks++; if (O_tag !== 1'b1) begin n_fail++; $display("FAIL b2b_tag[%0d]: got %b want 1", n, O_tag); end
                n++;
            end
            @(negedge clk);
            if (acc) idx++;
        end
        I_1_valid = 1'b0;
        n_checks++; if (n != 4) begin n_fail++; $display("FAIL b2b_count: got %0d beats want 4", n); end
        for (int i = 0; i < n; i++) begin
            n_checks++; if (got_data[i] !== 5'(8'h15 + i)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_data[i], 5'(8'h15 + i)); end
            n_checks++; if (got_cyc[i] != got_cyc[0] + i) begin n_fail++; $display("FAIL b2b_gap[%0d]: got cycle %0d want %0d", i, got_cyc[i], got_cyc[0] + i); end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] got_data [3];
        logic             acc;
        int idx, n;
        do_reset();
        O_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 12 && idx < 3; c++) begin
            I_1_valid = 1'b1;
            I_1_data  = 5'(8'h05 + idx);
            acc = I_1_ready;
            @(negedge clk);
            if (acc) idx++;
        end
        I_1_valid = 1'b0;
        n_checks++; if (idx != 3) begin n_fail++; $display("FAIL bp_accepts: got %0d want 3", idx); end
        n_checks++; if (I_1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", I_1_ready); end
        for (int s = 0; s < 3; s++) begin
            n_checks++; if (O_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", s, O_valid); end
            n_checks++; if (O_data !== 5'h05) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %h want 05", s, O_data); end
            n_checks++; if (O_tag !== 1'b1) begin n_fail++; $display("FAIL bp_hold_tag[%0d]: got %b want 1", s, O_tag); end
            @(negedge clk);
        end
        O_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 12 && n < 3; c++) begin
            if (O_valid === 1'b1) begin
                got_data[n] = O_data;
                $display("backpressure: drain beat %0d tag=%0d data=%h", n, O_tag, O_data);
                n++;
            end
            @(negedge clk);
        end
        n_checks++; if (n != 3) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 3", n); end
        for (int i = 0; i < n; i++) begin
            n_checks++; if (got_data[i] !== 5'(8'h05 + i)) begin n_fail++; $display("FAIL bp_drain_data[%0d]: got %h want %h", i, got_data[i], 5'(8'h05 + i)); end
        end
        n_checks++; if (O_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle_after: got %b want 0", O_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [WIDTH-1:0] got_data [4];
        logic             acc;
        int idx, n;
        do_reset();
        O_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 12 && idx < 3; c++) begin
            I_0_valid = 1'b1;
            I_0_data  = 5'(8'h0B + idx);
            acc = I_0_ready;
            @(negedge clk);
            if (acc) idx++;
        end
        n_checks++; if (idx != 3) begin n_fail++; $display("FAIL fpp_fill: got %0d want 3", idx); end
        // FIFO full, output stalled: offer another beat while releasing the output
        I_0_valid = 1'b1;
        I_0_data  = 5'h0E;
        O_ready   = 1'b1;
        n_checks++; if (I_0_ready !== 1'b0) begin n_fail++; $display("FAIL fpp_ready_on_pop: got %b want 0", I_0_ready); end
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            if (O_valid === 1'b1) begin
                got_data[n] = O_data;
                $display("full_push_pop: beat %0d tag=%0d data=%h", n, O_tag, O_data);
                n_checks++; if (O_tag !== 1'b0) begin n_fail++; $display("FAIL fpp_tag[%0d]: got %b want 0", n, O_tag); end
                n++;
            end
            acc = I_0_valid && I_0_ready;
            @(negedge clk);
            if (acc) I_0_valid = 1'b0;
        end
        I_0_valid = 1'b0;
        n_checks++; if (n != 4) begin n_fail++; $display("FAIL fpp_count: got %0d want 4", n); end
        for (int i = 0; i < n; i++) begin
            n_checks++; if (got_data[i] !== 5'(8'h0B + i)) begin n_fail++; $display("FAIL fpp_data[%0d]: got %h want %h", i, got_data[i], 5'(8'h0B + i)); end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        O_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            I_0_valid = 1'b1;
            I_0_data  = 5'h1F;
            I_1_valid = 1'b1;
            I_1_data  = 5'h1E;
            @(negedge clk);
        end
        I_0_valid = 1'b0;
        I_1_valid = 1'b0;
        n_checks++; if (O_valid !== 1'b1) begin n_fail++; $display("FAIL mid_loaded: got %b want 1", O_valid); end
        #2;
        ASYNCRESET = 1'b1;
        #1;
        n_checks++; if (O_valid !== 1'b0) begin n_fail++; $display("FAIL mid_o_valid: got %b want 0", O_valid); end
        n_checks++; if (O_data !== 5'h00) begin n_fail++; $display("FAIL mid_o_data: got %h want 00", O_data); end
        n_checks++; if (I_0_ready !== 1'b0) begin n_fail++; $display("FAIL mid_i0_ready: got %b want 0", I_0_ready); end
        n_checks++; if (I_1_ready !== 1'b0) begin n_fail++; $display("FAIL mid_i1_ready: got %b want 0", I_1_ready); end
        @(negedge clk);
        ASYNCRESET = 1'b0;
        O_ready    = 1'b1;
        #1;
        n_checks++; if (I_0_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_i0: got %b want 1", I_0_ready); end
        n_checks++; if (I_1_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_i1: got %b want 1", I_1_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if (O_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: got O_valid=%b data=%h want 0", c, O_valid, O_data); end
        end
        $display("reset_midstream: done");
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_contention();
        test_back_to_back();
        test_backpressure();
        test_full_push_pop();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
